// File: rtl/mask_deserializer.sv
// Mask deserializer: gathers OP_CHANNEL_WIDTH-bit chunks from the serial mask link into one
// IP_CHANNEL_WIDTH-bit row mask. Row length (16/32/54 chunks) is chosen per row by imageResolution.
// Optional feature: define MASK_DESER_ROWCNT_EN to add a 16-bit delivered-row counter output.
module mask_deserializer #(
  parameter int unsigned OP_CHANNEL_WIDTH = 20,
  parameter int unsigned IP_CHANNEL_WIDTH = 1080,
  parameter int unsigned stepSel0         = 16,
  parameter int unsigned stepSel1         = 32,
  parameter int unsigned stepSel2         = 54
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic [OP_CHANNEL_WIDTH-1:0] DIN,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [1:0]                  imageResolution,
  input  logic                        flush,
  output logic [IP_CHANNEL_WIDTH-1:0] DOUT,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        busy
`ifdef MASK_DESER_ROWCNT_EN
  ,
  output logic [15:0]                 row_count
`endif
);

  localparam int unsigned NumSlots = IP_CHANNEL_WIDTH / OP_CHANNEL_WIDTH;
  localparam int unsigned CntW     = $clog2(NumSlots + 1);
  localparam int unsigned IdxW     = $clog2(IP_CHANNEL_WIDTH);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [CntW-1:0]             steps_q, steps_d;
  logic [CntW-1:0]             steps_sel;
  logic [IP_CHANNEL_WIDTH-1:0] dout_q, dout_d;
  logic [IdxW-1:0]             wr_base;
  logic                        chunk_xfer;
  logic                        row_xfer;

  // Zero every bit that lies beyond the last chunk slot of a row of the given length.
  function automatic logic [IP_CHANNEL_WIDTH-1:0] clear_unused(
    input logic [IP_CHANNEL_WIDTH-1:0] row,
    input logic [CntW-1:0]             steps
  );
    logic [IP_CHANNEL_WIDTH-1:0] r;
    r = row;
    for (int unsigned i = 0; i < IP_CHANNEL_WIDTH; i++) begin
      if (i >= 32'(steps) * OP_CHANNEL_WIDTH) r[i[IdxW-1:0]] = 1'b0;
    end
    return r;
  endfunction

  // Outputs follow directly from the registered state.
  assign dout_valid = (state_q == StHold);
  assign busy       = (state_q == StCollect);
  assign din_ready  = (state_q != StHold) | dout_ready;
  assign DOUT       = dout_q;

  assign chunk_xfer = din_valid & din_ready & clk_en;
  assign row_xfer   = dout_valid & dout_ready & clk_en;
  assign wr_base    = IdxW'(cnt_q) * IdxW'(OP_CHANNEL_WIDTH);

  // Decode the row length requested for a row that starts this cycle.
  always_comb begin
    case (imageResolution)
      2'b00:   steps_sel = CntW'(stepSel0);
      2'b01:   steps_sel = CntW'(stepSel1);
      default: steps_sel = CntW'(stepSel2);
    endcase
  end

  // Next-state: chunk placement, row completion, flush and row hand-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (chunk_xfer) begin
          steps_d                         = steps_sel;
          dout_d[OP_CHANNEL_WIDTH-1:0]    = DIN;
          if (steps_sel == CntW'(1)) begin
            dout_d  = clear_unused(dout_d, steps_sel);
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (clk_en && flush) begin
          // Flush beats a same-cycle chunk; DOUT keeps its partial contents.
          cnt_d   = '0;
          state_d = StIdle;
        end else if (chunk_xfer) begin
          dout_d[wr_base +: OP_CHANNEL_WIDTH] = DIN;
          if (cnt_q == steps_q - CntW'(1)) begin
            dout_d  = clear_unused(dout_d, steps_q);
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (row_xfer) begin
          if (chunk_xfer) begin
            // The accepted chunk opens the next row in the same cycle.
            steps_d                      = steps_sel;
            dout_d                       = '0;
            dout_d[OP_CHANNEL_WIDTH-1:0] = DIN;
            if (steps_sel == CntW'(1)) begin
              cnt_d   = '0;
              state_d = StHold;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StCollect;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      steps_q <= CntW'(stepSel0);
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      dout_q  <= dout_d;
    end
  end

`ifdef MASK_DESER_ROWCNT_EN
  logic [15:0] row_cnt_q, row_cnt_d;

  // Count delivered rows; wraps naturally at 16 bits.
  always_comb begin
    row_cnt_d = row_xfer ? row_cnt_q + 16'd1 : row_cnt_q;
  end

  // Row counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_cnt_q <= '0;
    else        row_cnt_q <= row_cnt_d;
  end

  assign row_count = row_cnt_q;
`endif

endmodule

// File: tb/tb_mask_deserializer.sv
// Directed self-checking bench for mask_deserializer (default 20-bit chunks, 1080-bit rows).
module tb_mask_deserializer;

  localparam int W     = 20;
  localparam int RowW  = 1080;
  localparam int Slots = 54;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clk_en;
  logic [W-1:0]    din;
  logic            din_valid;
  logic            din_ready;
  logic [1:0]      img_res;
  logic            flush;
  logic [RowW-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            busy;
`ifdef MASK_DESER_ROWCNT_EN
  logic [15:0]     row_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_slot [Slots];

  mask_deserializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_en          (clk_en),
    .DIN             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .imageResolution (img_res),
    .flush           (flush),
    .DOUT            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .busy            (busy)
`ifdef MASK_DESER_ROWCNT_EN
    ,
    .row_count       (row_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one chunk and hold it until it transfers (bounded).
  task automatic push(input logic [W-1:0] d, input logic [1:0] r);
    int waits;
    din       = d;
    img_res   = r;
    din_valid = 1'b1;
    waits     = 0;
    while (!din_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (waits >= 20) check_eq("push_timeout", 64'(waits), 64'd0);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    din_valid = 1'b0;
    tick();
  endtask

  task automatic check_dout(input string tag);
    for (int k = 0; k < Slots; k++) begin
      check_eq($sformatf("%s_slot%0d", tag, k), 64'(dout[k*W +: W]), 64'(exp_slot[k]));
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < Slots; k++) exp_slot[k] = '0;
  endtask

  initial begin
    int early;
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    img_res    = 2'b00;
    flush      = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();

    // Reset values
    check_eq("rst_dout_valid", 64'(dout_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_din_ready", 64'(din_ready), 64'd1);
    check_eq("rst_dout_zero", 64'(|dout), 64'd0);
    rst_n = 1'b1;
    tick();

    // 640 mode: 32 chunks k+1
    clear_exp();
    for (int k = 0; k < 32; k++) begin
      push(W'(k + 1), 2'b01);
      exp_slot[k] = W'(k + 1);
      if (k == 0) check_eq("r640_busy", 64'(busy), 64'd1);
      if (k == 30) check_eq("r640_pre_valid", 64'(dout_valid), 64'd0);
    end
    check_eq("r640_valid", 64'(dout_valid), 64'd1);
    check_dout("r640");
    idle_cycle();
    check_eq("r640_taken", 64'(dout_valid), 64'd0);

    // 320 row, then 1080 row of ones started in the same cycle the 320 row leaves
    clear_exp();
    for (int k = 0; k < 16; k++) begin
      push(W'(32'hA0000 + k), 2'b00);
      exp_slot[k] = W'(32'hA0000 + k);
    end
    check_eq("r320_valid", 64'(dout_valid), 64'd1);
    check_dout("r320");
    for (int k = 0; k < 54; k++) begin
      push(20'hFFFFF, 2'b11);
      exp_slot[k] = 20'hFFFFF;
      if (k == 0) begin
        check_eq("r1080_start_valid", 64'(dout_valid), 64'd0);
        check_eq("r1080_start_busy", 64'(busy), 64'd1);
      end
    end
    check_eq("r1080_valid", 64'(dout_valid), 64'd1);
    check_dout("r1080");
    idle_cycle();

    // Back-pressure
    dout_ready = 1'b0;
    clear_exp();
    for (int k = 0; k < 16; k++) push(W'(32'h11110 + k), 2'b00);
    check_eq("bp_valid", 64'(dout_valid), 64'd1);
    din       = 20'h55555;
    img_res   = 2'b00;
    din_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_din_ready", 64'(din_ready), 64'd0);
      check_eq("bp_hold_valid", 64'(dout_valid), 64'd1);
      check_eq("bp_stable_slot0", 64'(dout[0 +: W]), 64'h11110);
      check_eq("bp_stable_slot15", 64'(dout[15*W +: W]), 64'h1111F);
    end
    dout_ready = 1'b1;
    #1;
    check_eq("bp_ready_follows", 64'(din_ready), 64'd1);
    tick();
    din_valid = 1'b0;
    check_eq("bp_after_valid", 64'(dout_valid), 64'd0);
    check_eq("bp_after_busy", 64'(busy), 64'd1);
    check_eq("bp_new_slot0", 64'(dout[0 +: W]), 64'h55555);
    check_eq("bp_cleared_slot1", 64'(dout[W +: W]), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("bp_flush_idle", 64'(busy), 64'd0);

    // Flush: 10 chunks, flush with a competing chunk, then a clean row
    for (int k = 0; k < 10; k++) push(W'(32'hBAD00 + k), 2'b01);
    din       = 20'hDEAD0;
    din_valid = 1'b1;
    flush     = 1'b1;
    tick();
    din_valid = 1'b0;
    flush     = 1'b0;
    check_eq("fl_busy", 64'(busy), 64'd0);
    check_eq("fl_valid", 64'(dout_valid), 64'd0);
    check_eq("fl_keep_slot9", 64'(dout[9*W +: W]), 64'hBAD09);
    check_eq("fl_drop_chunk", 64'(dout[10*W +: W]), 64'd0);
    clear_exp();
    early = 0;
    for (int k = 0; k < 32; k++) begin
      push(W'(32'h30000 + k), 2'b01);
      exp_slot[k] = W'(32'h30000 + k);
      if (k < 31 && dout_valid) early++;
    end
    check_eq("fl_early_rows", 64'(early), 64'd0);
    check_eq("fl_valid_end", 64'(dout_valid), 64'd1);
    check_dout("fl_row");
    idle_cycle();

    // clk_en low: handshake ignored
    clk_en    = 1'b0;
    din       = 20'h0000C;
    din_valid = 1'b1;
    tick();
    tick();
    check_eq("cken_busy", 64'(busy), 64'd0);
    din_valid = 1'b0;
    clk_en    = 1'b1;

    // Resolution change mid-row
    clear_exp();
    for (int k = 0; k < 16; k++) begin
      push(W'(32'h50000 + k), (k < 6) ? 2'b00 : 2'b10);
      exp_slot[k] = W'(32'h50000 + k);
      if (k == 14) check_eq("res_pre_valid", 64'(dout_valid), 64'd0);
    end
    check_eq("res_valid_16", 64'(dout_valid), 64'd1);
    check_dout("res_row");
    idle_cycle();

    // Reset mid-row
    for (int k = 0; k < 20; k++) push(W'(32'h70000 + k), 2'b10);
    din       = 20'h70014;
    din_valid = 1'b1;
    rst_n     = 1'b0;
    #2;
    check_eq("mrst_valid", 64'(dout_valid), 64'd0);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_din_ready", 64'(din_ready), 64'd1);
    check_eq("mrst_dout_zero", 64'(|dout), 64'd0);
    din_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef MASK_DESER_ROWCNT_EN
    check_eq("rc_reset", 64'(row_count), 64'd0);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) push(W'(k), 2'b00);
      idle_cycle();
    end
    check_eq("rc_three", 64'(row_count), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
